// File: rtl/mmio_output_bridge.sv
// Core-to-memory port A bridge with a 16-byte MMIO window.
// TX stores fill a byte FIFO that drains to an external sink over valid/ready.
module mmio_output_bridge #(
  parameter int          WORD_WIDTH_IN_BIT = 32,
  parameter logic [31:0] IO_BASE_ADDR      = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH        = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           core_en_a,
  input  logic [3:0]                     core_we_a,
  input  logic [31:0]                    core_addr_a,
  input  logic [WORD_WIDTH_IN_BIT-1:0]   core_din_a,
  output logic [WORD_WIDTH_IN_BIT-1:0]   core_dout_a,
  output logic                           mem_en_a,
  output logic [3:0]                     mem_we_a,
  output logic [31:0]                    mem_addr_a,
  output logic [WORD_WIDTH_IN_BIT-1:0]   mem_din_a,
  input  logic [WORD_WIDTH_IN_BIT-1:0]   mem_dout_a,
  output logic                           io_output_valid,
  output logic [7:0]                     io_output_data,
  input  logic                           io_output_ready,
  output logic [$clog2(FIFO_DEPTH):0]    io_buffer_size_avai
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFS_TX   = 4'h0;
  localparam logic [3:0] OFS_STAT = 4'h4;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             sel_io_q;
  logic [31:0]      io_rdata_q;

  logic             is_io;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             stat_wr;
  logic [CNT_W-1:0] free_cnt;
  logic [31:0]      mmio_rdata;

  assign is_io    = (core_addr_a[31:4] == IO_BASE_ADDR[31:4]);
  assign full     = (count == DEPTH_C);
  assign free_cnt = DEPTH_C - count;

  assign push_req = core_en_a & is_io & (core_addr_a[3:0] == OFS_TX) & core_we_a[0];
  assign stat_wr  = core_en_a & is_io & (core_addr_a[3:0] == OFS_STAT) & (|core_we_a);
  assign pop      = io_output_valid & io_output_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    mmio_rdata = 32'h0;
    if (core_addr_a[3:0] == OFS_STAT)
      mmio_rdata = {overflow_q, 15'b0, {(16-CNT_W){1'b0}}, free_cnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
      if (push_req && !push_ok)
        overflow_q <= 1'b1;
      else if (stat_wr)
        overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= core_din_a[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_io_q   <= 1'b0;
      io_rdata_q <= 32'h0;
    end else if (core_en_a) begin
      sel_io_q   <= is_io;
      io_rdata_q <= mmio_rdata;
    end
  end

  assign core_dout_a         = sel_io_q ? io_rdata_q : mem_dout_a;
  assign mem_en_a            = core_en_a & ~is_io;
  assign mem_we_a            = is_io ? 4'b0 : core_we_a;
  assign mem_addr_a          = core_addr_a;
  assign mem_din_a           = core_din_a;
  assign io_output_valid     = (count != '0);
  assign io_output_data      = fifo_mem[rd_ptr];
  assign io_buffer_size_avai = free_cnt;

endmodule

// File: tb/tb_mmio_output_bridge.sv
// Randomized and directed bench for mmio_output_bridge against a queue-based model.
module tb_mmio_output_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_en_a;
  logic [3:0]  core_we_a;
  logic [31:0] core_addr_a;
  logic [31:0] core_din_a;
  logic [31:0] core_dout_a;
  logic        mem_en_a;
  logic [3:0]  mem_we_a;
  logic [31:0] mem_addr_a;
  logic [31:0] mem_din_a;
  logic [31:0] mem_dout_a;
  logic        io_output_valid;
  logic [7:0]  io_output_data;
  logic        io_output_ready;
  logic [4:0]  io_buffer_size_avai;

  always #5 clk = ~clk;

  mmio_output_bridge dut (
    .clk(clk), .reset(reset),
    .core_en_a(core_en_a), .core_we_a(core_we_a), .core_addr_a(core_addr_a),
    .core_din_a(core_din_a), .core_dout_a(core_dout_a),
    .mem_en_a(mem_en_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
    .mem_din_a(mem_din_a), .mem_dout_a(mem_dout_a),
    .io_output_valid(io_output_valid), .io_output_data(io_output_data),
    .io_output_ready(io_output_ready), .io_buffer_size_avai(io_buffer_size_avai)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  byte unsigned m_q[$];
  bit           m_ovf;
  bit           m_sel;
  logic [31:0]  m_rdata;

  // Observations from the most recent step
  logic [31:0] obs_dout, obs_mem;
  logic        obs_valid;
  logic [7:0]  obs_data;
  logic [4:0]  obs_avail;
  logic [3:0]  obs_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= 32'hFFFF_FF00) && (a <= 32'hFFFF_FF0F);
  endfunction

  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] din, input bit rdy);
    bit io, push, pop, stat_clr;
    int sz;
    @(negedge clk);
    reset = rst; core_en_a = en; core_we_a = we; core_addr_a = addr;
    core_din_a = din; io_output_ready = rdy; mem_dout_a = $urandom;
    #1;
    io = in_window(addr);
    sz = m_q.size();
    obs_dout = core_dout_a; obs_mem = mem_dout_a; obs_valid = io_output_valid;
    obs_data = io_output_data; obs_avail = io_buffer_size_avai; obs_we = mem_we_a;
    check("valid", {31'b0, io_output_valid}, {31'b0, sz != 0});
    if (sz != 0) check("data", {24'b0, io_output_data}, {24'b0, m_q[0]});
    check("avail", {27'b0, io_buffer_size_avai}, 32'(16 - sz));
    check("mem_en", {31'b0, mem_en_a}, {31'b0, en && !io});
    check("mem_we", {28'b0, mem_we_a}, io ? 32'h0 : {28'b0, we});
    check("mem_addr", mem_addr_a, addr);
    check("mem_din", mem_din_a, din);
    check("dout", core_dout_a, m_sel ? m_rdata : mem_dout_a);
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_ovf = 0; m_sel = 0; m_rdata = 0;
    end else begin
      pop      = (sz != 0) && rdy;
      push     = en && io && (addr[3:0] == 4'h0) && we[0];
      stat_clr = en && io && (addr[3:0] == 4'h4) && (we != 0);
      if (en) begin
        m_sel   = io;
        m_rdata = (addr[3:0] == 4'h4) ? {m_ovf, 15'b0, 16'(16 - sz)} : 32'h0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz < 16 || pop) m_q.push_back(din[7:0]);
        else m_ovf = 1;
      end else if (stat_clr) m_ovf = 0;
      if (push && !(sz < 16 || pop)) m_ovf = 1;
      else if (stat_clr && push) m_ovf = 0;
    end
  endtask

  localparam logic [31:0] TX   = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF04;

  task automatic idle(input bit rdy);
    step(0, 0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic stat_read(input bit rdy);
    step(0, 1, 4'h0, STAT, 32'h0, rdy);
  endtask

  initial begin
    reset = 1; core_en_a = 0; core_we_a = 0; core_addr_a = 0; core_din_a = 0;
    io_output_ready = 0; mem_dout_a = 0;
    m_ovf = 0; m_sel = 0; m_rdata = 0;

    // 1: reset then idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(0);
    check("t1_valid", {31'b0, obs_valid}, 32'h0);
    check("t1_avail", {27'b0, obs_avail}, 32'd16);
    stat_read(0);
    idle(0);
    check("t1_stat", obs_dout, 32'h0000_0010);

    // 2: single store drains immediately
    step(0, 1, 4'h1, TX, 32'h0000_0041, 1);
    check("t2_mem_we", {28'b0, obs_we}, 32'h0);
    idle(1);
    check("t2_valid", {31'b0, obs_valid}, 32'h1);
    check("t2_data", {24'b0, obs_data}, 32'h41);
    idle(1);
    check("t2_empty", {31'b0, obs_valid}, 32'h0);

    // 3: overfill, then drain in order
    for (int i = 0; i < 17; i++) step(0, 1, 4'h1, TX, 32'(i), 0);
    stat_read(0);
    idle(0);
    check("t3_stat", obs_dout, 32'h8000_0000);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      check("t3_drain", {24'b0, obs_data}, 32'(i));
    end
    idle(0);
    check("t3_empty", {31'b0, obs_valid}, 32'h0);

    // 4: full FIFO, push and pop in the same cycle
    step(0, 1, 4'hF, STAT, 32'h0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'h1, TX, 32'(8'hA0 + i), 0);
    step(0, 1, 4'h1, TX, 32'h0000_00BB, 1);
    stat_read(0);
    idle(0);
    check("t4_stat", obs_dout, 32'h0000_0000);

    // 5: memory load then STAT back to back
    step(0, 1, 4'h0, 32'h0000_0100, 32'h0, 0);
    stat_read(0);
    check("t5_mem_dout", obs_dout, obs_mem);
    idle(0);
    check("t5_io_dout", obs_dout, 32'h0000_0000);

    // 6: reset mid-drain discards contents
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 4'h1, TX, 32'(i + 1), 0);
    step(1, 0, 0, 0, 0, 0);
    idle(0);
    check("t6_valid", {31'b0, obs_valid}, 32'h0);
    check("t6_avail", {27'b0, obs_avail}, 32'd16);
    stat_read(0);
    idle(0);
    check("t6_stat", obs_dout, 32'h0000_0010);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = TX;
      else if (sel < 7) a = STAT;
      else if (sel < 8) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 15));
      else              a = $urandom;
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 3) != 0,
           4'($urandom), a, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
